life_engine: RTL

- Owns the 8x8 Game of Life board and computes each new generation, one cell per clock.
- Feeds the VGA display renderer: that renderer supplies a 2-bit quadrant select and reads back the current and previous 16-cell quadrant words.
- The renderer colours each cell from the (previous, current) pair.
- A step is requested by a one-cycle strobe, typically a frame or timer tick. Seeding is done by a 64-bit parallel load.

---
 rtl/life_engine_pkg.sv | 28 ++
 rtl/life_engine_if.sv | 24 ++
 rtl/life_engine_rule.sv | 50 +++++
 rtl/life_engine.sv | 120 ++++++++++++
 4 files changed

// File: rtl/life_engine_pkg.sv
// -----------------------------------------------------------------------------
// life_engine_pkg
// Shared definitions for the 8x8 Game of Life engine.
//   - Board geometry constants (cell count, side length, quadrant width).
//   - Engine FSM state encoding.
//   - pack_idx(): maps a cell (X,Y) to its flat index. The flat index is
//     {X[2],Y[2],X[1:0],Y[1:0]}: the top two bits pick the 4x4 quadrant, the
//     low four bits pick the cell inside it. Seed bits, board registers and
//     the scan index all use this layout.
// No ports (package).
// -----------------------------------------------------------------------------
package life_engine_pkg;

    localparam int BOARD_BITS = 64;
    localparam int BOARD_DIM  = 8;
    localparam int QUAD_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [5:0] pack_idx(input logic [2:0] x, input logic [2:0] y);
        return {x[2], y[2], x[1:0], y[1:0]};
    endfunction

endpackage

// File: rtl/life_engine_if.sv
// -----------------------------------------------------------------------------
// life_engine_if
// Quadrant read bus between the display renderer and the life engine.
//   array_pos  : quadrant select {X[2],Y[2]}, driven by the renderer
//   alive      : current generation of the selected quadrant
//   alive_prev : previous generation of the selected quadrant
// Modports:
//   master : renderer side (drives array_pos, reads the two words)
//   slave  : engine side (returns the two words)
// The read is purely combinational: there is no valid/ready pair; the words
// follow array_pos within the same cycle and are stable for the whole of a
// step because the current board only changes on commit, load or reset.
// -----------------------------------------------------------------------------
interface life_engine_if;
    import life_engine_pkg::*;

    logic [1:0]        array_pos;
    logic [QUAD_W-1:0] alive;
    logic [QUAD_W-1:0] alive_prev;

    modport master (output array_pos, input alive, input alive_prev);
    modport slave  (input array_pos, output alive, output alive_prev);

endinterface

// File: rtl/life_engine_rule.sv
// -----------------------------------------------------------------------------
// life_engine_rule
// Combinational next-state of one cell of the toroidal 8x8 board.
// Ports:
//   i_board : full 64-bit board (flat index layout from life_engine_pkg)
//   i_idx   : flat index of the cell being evaluated
//   o_next  : cell value in the next generation
// Neighbours are the eight cells at X+-1, Y+-1 with wrap on both axes;
// a live cell survives on 2 or 3 neighbours, a dead cell is born on 3.
// -----------------------------------------------------------------------------
module life_engine_rule
    import life_engine_pkg::*;
(
    input  logic [BOARD_BITS-1:0] i_board,
    input  logic [5:0]            i_idx,
    output logic                  o_next
);

    logic [2:0] w_x;
    logic [2:0] w_y;
    logic [2:0] w_nx;
    logic [2:0] w_ny;
    logic [3:0] w_count;

    assign w_x = {i_idx[5], i_idx[3:2]};
    assign w_y = {i_idx[4], i_idx[1:0]};

    always_comb begin
        w_count = '0;
        w_nx    = '0;
        w_ny    = '0;
        for (int dx = 0; dx < 3; dx++) begin
            for (int dy = 0; dy < 3; dy++) begin
                if (!(dx == 1 && dy == 1)) begin
                    // Adding 7 in 3-bit arithmetic is a mod-8 decrement, so
                    // offsets 0/1/2 become -1/0/+1 with toroidal wrap for free.
                    w_nx    = w_x + 3'(dx) + 3'd7;
                    w_ny    = w_y + 3'(dy) + 3'd7;
                    w_count = w_count + {3'b000, i_board[pack_idx(w_nx, w_ny)]};
                end
            end
        end
        if (i_board[i_idx]) begin
            o_next = (w_count == 4'd2) || (w_count == 4'd3);
        end else begin
            o_next = (w_count == 4'd3);
        end
    end

endmodule

// File: rtl/life_engine.sv
// -----------------------------------------------------------------------------
// life_engine
// Owns the 8x8 Game of Life board and computes one new generation per step,
// evaluating one cell per clock into a scratch board, then committing it.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load, seed   : one-cycle strobe copying seed into the board (any state;
//                  aborts a step in progress without a done pulse)
//   step         : one-cycle strobe starting a generation (ignored when busy)
//   rd_if        : renderer quadrant read bus (slave side)
//   busy         : high while calculating or committing
//   done         : one-cycle pulse after a generation is committed
//   generation   : committed generation count (wraps)
//   o_dbg_state  : current FSM state, for observation only
// Timing: step sampled at edge N -> 64 scan edges N+1..N+64 -> commit at
// edge N+65, done high during the following cycle.
// -----------------------------------------------------------------------------
module life_engine
    import life_engine_pkg::*;
#(
    parameter int GEN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BOARD_BITS-1:0] seed,
    input  logic                  step,
    life_engine_if.slave          rd_if,
    output logic                  busy,
    output logic                  done,
    output logic [GEN_W-1:0]      generation,
    output state_t                o_dbg_state
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BOARD_BITS-1:0] r_cur;
    logic [BOARD_BITS-1:0] r_prev;
    logic [BOARD_BITS-1:0] r_next;
    logic [GEN_W-1:0]      r_gen;
    logic [5:0]            r_idx;
    logic                  r_done;
    logic                  w_rule_bit;

    life_engine_rule u_rule (
        .i_board (r_cur),
        .i_idx   (r_idx),
        .o_next  (w_rule_bit)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!load && step) begin
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (load) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_idx == 6'd63) begin
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_prev  <= '0;
            r_next  <= '0;
            r_gen   <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            // load wins in every state; during a step it abandons the scratch
            // board untouched and suppresses the commit.
            if (load) begin
                r_cur  <= seed;
                r_prev <= '0;
                r_gen  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (step) begin
                            r_idx <= '0;
                        end
                    end
                    ST_CALC: begin
                        r_next[r_idx] <= w_rule_bit;
                        r_idx         <= r_idx + 6'd1;
                    end
                    ST_COMMIT: begin
                        r_prev <= r_cur;
                        r_cur  <= r_next;
                        r_gen  <= r_gen + 1'b1;
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rd_if.alive      = r_cur[{rd_if.array_pos, 4'b0000} +: QUAD_W];
    assign rd_if.alive_prev = r_prev[{rd_if.array_pos, 4'b0000} +: QUAD_W];

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign generation  = r_gen;
    assign o_dbg_state = r_state;

endmodule
